// File: rtl/instr_fetch_seq_if.sv
// Instruction sequencer bus interface.
// Groups the loader/control side (start, program RAM write port) with the CU-facing
// outputs (instr, pc, busy, halted).
//   master : loader/testbench side, drives start/prog_*, observes outputs
//   slave  : the sequencer itself
interface instr_fetch_seq_if #(
  parameter int unsigned INSTR_WIDTH = 20,
  parameter int unsigned PC_BITS     = 4
);
  logic                   start;
  logic                   prog_we;
  logic [PC_BITS-1:0]     prog_addr;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_BITS-1:0]     pc;
  logic                   busy;
  logic                   halted;

  modport master (
    output start, prog_we, prog_addr, prog_data,
    input  instr, pc, busy, halted
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data,
    output instr, pc, busy, halted
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// Instruction sequencer for the control unit.
// Holds a 2**PC_BITS word program RAM and presents one instruction at a time on instr,
// keeping it stable for as many cycles as the CU FSM spends on that instruction type.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset (RAM contents are kept)
//   bus  : instr_fetch_seq_if.slave
//          start     1-cycle pulse, begin at PC 0 (IDLE only)
//          prog_we   program RAM write enable (IDLE only)
//          prog_addr program RAM write address
//          prog_data program RAM write data
//          instr     registered instruction to CU
//          pc        address of the instruction on instr
//          busy      high in ISSUE
//          halted    high in HALT
// Configuration macro: IFETCH_LOOP_EN
//   defined   : after the last address, wrap to 0 and keep issuing (no lead cycle)
//   undefined : after the last address, enter HALT with pc left at the last address
module instr_fetch_seq #(
  parameter int unsigned INSTR_WIDTH  = 20,
  parameter int unsigned PC_BITS      = 4,
  parameter int unsigned LEAD_CYCLES  = 1,
  parameter int unsigned STD_CYCLES   = 3,
  parameter int unsigned LOAD_CYCLES  = 4,
  parameter int unsigned STORE_CYCLES = 3
) (
  input logic             clk,
  input logic             rst,
  instr_fetch_seq_if.slave bus
);

  localparam int unsigned Depth = 2 ** PC_BITS;
  localparam int unsigned CntW  = $clog2(LEAD_CYCLES + LOAD_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StHalt} state_e;

  logic [INSTR_WIDTH-1:0] mem [Depth];

  state_e                 state_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_BITS-1:0]     pc_q;
  logic [CntW-1:0]        cnt_q;
  logic                   busy_q;
  logic                   halted_q;

  logic [INSTR_WIDTH-1:0] fetch_word;
  logic [PC_BITS-1:0]     fetch_addr;
  logic                   fetch_lead;
`ifndef IFETCH_LOOP_EN
  logic                   last_addr;
`endif

  // Cycles-minus-one the word stays on instr; counter counts down to zero.
  function automatic logic [CntW-1:0] hold_of(input logic [1:0] typ, input logic lead);
    int unsigned c;
    unique case (typ)
      2'b01:   c = STD_CYCLES;
      2'b10:   c = LOAD_CYCLES;
      2'b11:   c = STORE_CYCLES;
      default: c = 1;
    endcase
    if (lead) c = c + LEAD_CYCLES;
    return CntW'(c - 1);
  endfunction

  // Program RAM; not reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && bus.prog_we) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Word to fetch on the next advance. In IDLE a same-cycle write to address 0
  // is forwarded so start sees the new word.
  always_comb begin
    fetch_addr = pc_q + PC_BITS'(1);
    fetch_word = mem[fetch_addr];
    fetch_lead = 1'b0;
    if (state_q == StIdle) begin
      fetch_addr = '0;
      fetch_word = (bus.prog_we && bus.prog_addr == '0) ? bus.prog_data : mem[0];
      fetch_lead = 1'b1;
    end
  end

`ifndef IFETCH_LOOP_EN
  assign last_addr = (pc_q == PC_BITS'(Depth - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      instr_q  <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StIssue: begin
          if ((state_q == StIdle && bus.start) || (state_q == StIssue && cnt_q == '0)) begin
`ifndef IFETCH_LOOP_EN
            if (state_q == StIssue && last_addr) begin
              state_q  <= StHalt;
              instr_q  <= '0;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else
`endif
            if (fetch_word[INSTR_WIDTH-1 -: 2] == 2'b00) begin
              // Type-00 word is the halt marker; pc records where it was found.
              state_q  <= StHalt;
              instr_q  <= '0;
              pc_q     <= fetch_addr;
              cnt_q    <= '0;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              state_q  <= StIssue;
              instr_q  <= fetch_word;
              pc_q     <= fetch_addr;
              cnt_q    <= hold_of(fetch_word[INSTR_WIDTH-1 -: 2], fetch_lead);
              busy_q   <= 1'b1;
              halted_q <= 1'b0;
            end
          end else if (state_q == StIssue) begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.instr  = instr_q;
  assign bus.pc     = pc_q;
  assign bus.busy   = busy_q;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  instr_fetch_seq_if #(.INSTR_WIDTH(20), .PC_BITS(4)) bus ();

  instr_fetch_seq #(
    .INSTR_WIDTH (20),
    .PC_BITS     (4),
    .LEAD_CYCLES (1),
    .STD_CYCLES  (3),
    .LOAD_CYCLES (4),
    .STORE_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic load(input logic [3:0] addr, input logic [19:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Checks instr/pc/busy for n consecutive cycles, advancing one clock after each.
  task automatic expect_hold(input string tag, input logic [19:0] word, input logic [3:0] addr,
                             input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, ".instr"}, 32'(bus.instr), 32'(word));
      check({tag, ".pc"}, 32'(bus.pc), 32'(addr));
      check({tag, ".busy"}, 32'(bus.busy), 32'd1);
      tick();
    end
  endtask

  task automatic expect_halt(input string tag, input logic [3:0] addr);
    check({tag, ".instr"}, 32'(bus.instr), 32'd0);
    check({tag, ".pc"}, 32'(bus.pc), 32'(addr));
    check({tag, ".busy"}, 32'(bus.busy), 32'd0);
    check({tag, ".halted"}, 32'(bus.halted), 32'd1);
  endtask

  initial begin
    logic [19:0] w;
    errors        = 0;
    checks        = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;

    // Test 1: reset state, single std_op with lead cycle, halt on zero word.
    do_reset();
    check("rst.instr", 32'(bus.instr), 32'd0);
    check("rst.pc", 32'(bus.pc), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.halted", 32'(bus.halted), 32'd0);
    load(4'd0, 20'h51230);
    load(4'd1, 20'h00000);
    check("idle.instr", 32'(bus.instr), 32'd0);
    pulse_start();
    expect_hold("t1.std", 20'h51230, 4'd0, 4);
    expect_halt("t1.halt", 4'd1);
    tick();
    expect_halt("t1.halt_stays", 4'd1);

    // Test 2: loadR then storeR; mem[0] written in the start cycle (write-first).
    do_reset();
    load(4'd1, 20'hD0020);
    load(4'd2, 20'h00000);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd0;
    bus.prog_data = 20'h90050;
    pulse_start();
    bus.prog_we   = 1'b0;
    expect_hold("t2.load", 20'h90050, 4'd0, 5);
    expect_hold("t2.store", 20'hD0020, 4'd1, 3);
    expect_halt("t2.halt", 4'd2);

    // Test 4: async reset in the middle of the loadR hold, then replay.
    do_reset();
    pulse_start();
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("t4.async.instr", 32'(bus.instr), 32'd0);
    check("t4.async.busy", 32'(bus.busy), 32'd0);
    check("t4.async.pc", 32'(bus.pc), 32'd0);
    tick();
    rst = 1'b1;
    pulse_start();
    expect_hold("t4.load", 20'h90050, 4'd0, 5);
    expect_hold("t4.store", 20'hD0020, 4'd1, 3);
    expect_halt("t4.halt", 4'd2);

    // Test 3: prog_we and start during ISSUE are ignored; halt position proves mem[3] kept.
    do_reset();
    load(4'd0, 20'h50001);
    load(4'd1, 20'h50002);
    load(4'd2, 20'h60003);
    load(4'd3, 20'h00000);
    pulse_start();
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd3;
    bus.prog_data = 20'h500FF;
    bus.start     = 1'b1;
    expect_hold("t3.w0a", 20'h50001, 4'd0, 1);
    bus.prog_we   = 1'b0;
    bus.start     = 1'b0;
    expect_hold("t3.w0b", 20'h50001, 4'd0, 3);
    expect_hold("t3.w1", 20'h50002, 4'd1, 3);
    expect_hold("t3.w2", 20'h60003, 4'd2, 3);
    expect_halt("t3.halt", 4'd3);
    do_reset();
    pulse_start();
    expect_hold("t3.rerun0", 20'h50001, 4'd0, 4);
    expect_hold("t3.rerun1", 20'h50002, 4'd1, 3);
    expect_hold("t3.rerun2", 20'h60003, 4'd2, 3);
    expect_halt("t3.rerun_halt", 4'd3);

    // Test 5: full program of std_ops, no halt word.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      w = 20'h40000 + 20'(i + 1);
      load(4'(i), w);
    end
    pulse_start();
    expect_hold("t5.w0", 20'h40001, 4'd0, 4);
    for (int i = 1; i < 16; i++) begin
      w = 20'h40000 + 20'(i + 1);
      expect_hold("t5.wn", w, 4'(i), 3);
    end
`ifdef IFETCH_LOOP_EN
    expect_hold("t5.wrap0", 20'h40001, 4'd0, 3);
    expect_hold("t5.wrap1", 20'h40002, 4'd1, 1);
`else
    expect_halt("t5.end_halt", 4'd15);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
